instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory with a self-clearing NOP fill, single-cycle registered fetch and a streamed program loader.
// Fetch latency 1 (IDLE only); loads stream in via ld_valid/ld_ready while LOAD, ending on ld_last or a full memory.
module instr_mem_loader #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    localparam int               IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [IDX_W:0]    ld_count,
    output logic              busy,
    output logic              err_oob
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   ld_count_q, ld_count_d;
    logic [DATA_W-1:0]  fetch_data_q, fetch_data_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               err_oob_q, err_oob_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic               fetch_oob;
    logic [IDX_W-1:0]   fetch_idx;
    logic               unused_ld_base_hi;

    assign fetch_idx         = fetch_addr[IDX_W-1:0];
    assign fetch_oob         = (fetch_addr[ADDR_W-1:IDX_W] != '0);
    // Load base is taken modulo DEPTH; its upper bits carry no meaning.
    assign unused_ld_base_hi = ^ld_base[ADDR_W-1:IDX_W];

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        ptr_d         = ptr_q;
        ld_count_d    = ld_count_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        err_oob_d     = err_oob_q;
        mem_we        = 1'b0;
        mem_waddr     = clr_idx_q;
        mem_wdata     = NOP_WORD;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (fetch_en) begin
                    fetch_valid_d = 1'b1;
                    if (fetch_oob) begin
                        fetch_data_d = NOP_WORD;
                        err_oob_d    = 1'b1;
                    end else begin
                        fetch_data_d = mem_q[fetch_idx];
                    end
                end
                if (ld_start) begin
                    ptr_d      = ld_base[IDX_W-1:0];
                    ld_count_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = ptr_q;
                    mem_wdata  = ld_data;
                    ptr_d      = ptr_q + 1'b1;
                    ld_count_d = ld_count_q + 1'b1;
                    // A full memory ends the load even without ld_last.
                    if (ld_last || (ld_count_q == CNT_W'(DEPTH - 1))) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_idx_q     <= '0;
            ptr_q         <= '0;
            ld_count_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= NOP_WORD;
            err_oob_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            ptr_q         <= ptr_d;
            ld_count_q    <= ld_count_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            err_oob_q     <= err_oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign ld_ready    = (state_q == LOAD);
    assign ld_count    = ld_count_q;
    assign busy        = (state_q == CLEAR) | (state_q == LOAD);
    assign err_oob     = err_oob_q;

endmodule
